// File: rtl/apb_uart_tx.sv
// UART transmitter fed from an upstream FIFO head (valid/ready pop handshake).
// Frame: start, 5..8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Every bit lasts divisor+1 clk cycles, timed by a down-counter reloaded at
// each bit boundary. The serial line is driven straight from a flop.
//
// state  | meaning
// IDLE   | line high, waiting for an enabled transfer
// START  | start bit (low)
// DATA   | data bits, LSB first, count set by latched word length
// PARITY | parity over the sent data bits (skipped when disabled)
// STOP   | one or two high stop bits, then back to IDLE
module apb_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en_i,
    input  logic [DIV_WIDTH-1:0]  divisor_i,
    input  logic [1:0]            data_bits_i,
    input  logic                  parity_en_i,
    input  logic                  parity_even_i,
    input  logic                  stop2_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [DIV_WIDTH-1:0]  baud_cnt, baud_next;
    logic [DIV_WIDTH-1:0]  divisor_q, divisor_next;
    logic [2:0]            bit_cnt, bit_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_next;
    logic [1:0]            data_bits_q, data_bits_next;
    logic                  parity_en_q, parity_en_next;
    logic                  parity_bit_q, parity_bit_next;
    logic                  stop2_q, stop2_next;
    logic                  tx_q, tx_next;
    logic                  accept;
    logic                  bit_done;
    logic [DATA_WIDTH-1:0] word_mask;
    logic [2:0]            last_bit;

    // Pop strobe is masked by reset so the FIFO never loses a word while held in reset.
    assign ready_o   = (state == IDLE) && tx_en_i && !reset;
    assign accept    = ready_o && valid_i;
    assign busy_o    = (state != IDLE);
    assign tx_o      = tx_q;
    assign bit_done  = (baud_cnt == '0);
    // 00..11 selects 5..8 bits: mask keeps the low 5..8 bits of the word.
    assign word_mask = {DATA_WIDTH{1'b1}} >> (2'd3 - data_bits_i);
    // Index of the final data bit is 4..7, i.e. 4 + word-length code.
    assign last_bit  = {1'b1, data_bits_q};

    // Next-state, bit timing and next line level for the frame sequencer.
    always_comb begin
        state_next      = state;
        baud_next       = baud_cnt;
        divisor_next    = divisor_q;
        bit_next        = bit_cnt;
        shift_next      = shift_q;
        data_bits_next  = data_bits_q;
        parity_en_next  = parity_en_q;
        parity_bit_next = parity_bit_q;
        stop2_next      = stop2_q;
        tx_next         = tx_q;

        if (state != IDLE) begin
            baud_next = bit_done ? divisor_q : baud_cnt - DIV_WIDTH'(1);
        end

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    state_next      = START;
                    baud_next       = divisor_i;
                    divisor_next    = divisor_i;
                    shift_next      = data_i;
                    data_bits_next  = data_bits_i;
                    parity_en_next  = parity_en_i;
                    stop2_next      = stop2_i;
                    // Parity is fixed at acceptance so later config edits cannot disturb it.
                    parity_bit_next = (^(data_i & word_mask)) ^ ~parity_even_i;
                    bit_next        = 3'd0;
                    tx_next         = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == last_bit) begin
                        if (parity_en_q) begin
                            state_next = PARITY;
                            tx_next    = parity_bit_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                            bit_next   = {2'b00, stop2_q};
                        end
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = shift_q >> 1;
                        tx_next    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    bit_next   = {2'b00, stop2_q};
                end
            end
            STOP: begin
                if (bit_done) begin
                    tx_next = 1'b1;
                    if (bit_cnt == 3'd0) begin
                        state_next = IDLE;
                    end else begin
                        bit_next = bit_cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // State, counters, latched word/config and the registered line output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            divisor_q    <= '0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            data_bits_q  <= '0;
            parity_en_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop2_q      <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state        <= state_next;
            baud_cnt     <= baud_next;
            divisor_q    <= divisor_next;
            bit_cnt      <= bit_next;
            shift_q      <= shift_next;
            data_bits_q  <= data_bits_next;
            parity_en_q  <= parity_en_next;
            parity_bit_q <= parity_bit_next;
            stop2_q      <= stop2_next;
            tx_q         <= tx_next;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Bench for apb_uart_tx: a frame-level model (queue of expected line levels)
// checked every cycle, plus literal frame patterns for the reference cases.
module tb_apb_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_en = 1'b0;
    logic [15:0] divisor = '0;
    logic [1:0]  data_bits = 2'b11;
    logic        parity_en = 1'b0;
    logic        parity_even = 1'b0;
    logic        stop2 = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = '0;
    logic        ready;
    logic        tx;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    logic exp_q[$];
    logic cap[$];
    int   n_acc = 0;
    int   idle_run = 0;
    int   last_gap = -1;
    logic mon_on = 1'b0;
    bit   idle_now;
    logic etx;

    apb_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_en_i       (tx_en),
        .divisor_i     (divisor),
        .data_bits_i   (data_bits),
        .parity_en_i   (parity_en),
        .parity_even_i (parity_even),
        .stop2_i       (stop2),
        .valid_i       (valid),
        .data_i        (data),
        .ready_o       (ready),
        .tx_o          (tx),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    // Spec-level frame: start, nb data bits LSB-first, parity, stop(s), each held div+1 cycles.
    task automatic push_frame(input logic [7:0] d, input int nb, input bit pen,
                              input bit peven, input bit s2, input int div);
        logic lvl[$];
        logic p;
        p = 1'b0;
        lvl.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            lvl.push_back(d[i]);
            p = p ^ d[i];
        end
        if (pen) lvl.push_back(peven ? p : !p);
        lvl.push_back(1'b1);
        if (s2) lvl.push_back(1'b1);
        foreach (lvl[i]) begin
            for (int r = 0; r <= div; r++) exp_q.push_back(lvl[i]);
        end
    endtask

    // Per-cycle compare against the model; also captures the line while busy.
    always @(negedge clk) begin
        if (mon_on) begin
            if (reset) begin
                chk("rst_tx", tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_ready", ready, 0);
                exp_q.delete();
                idle_run = 0;
            end else begin
                idle_now = (exp_q.size() == 0);
                etx = idle_now ? 1'b1 : exp_q.pop_front();
                chk("tx", tx, etx);
                chk("busy", busy, !idle_now);
                chk("ready", ready, idle_now && tx_en);
                if (busy) begin
                    cap.push_back(tx);
                    if (idle_run > 0) last_gap = idle_run;
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (idle_now && tx_en && valid) begin
                    n_acc++;
                    push_frame(data, int'(data_bits) + 5, parity_en, parity_even, stop2, int'(divisor));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a word and return just after the edge that accepts it (valid left high).
    task automatic send(input logic [7:0] d);
        int k;
        int a0;
        a0 = n_acc;
        data = d;
        valid = 1'b1;
        k = 0;
        while (n_acc == a0 && k < 100) begin
            step(1);
            k++;
        end
        if (n_acc == a0) timeout_fail("accept_wait");
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            step(1);
            k++;
        end
        if (busy) timeout_fail("idle_wait");
    endtask

    // lit bit i is the i-th transmitted bit; each must be held for hold cycles.
    task automatic check_cap(input string name, input int hold, input int nbits, input logic [31:0] lit);
        int mism;
        chk({name, "_len"}, cap.size(), hold * nbits);
        mism = 0;
        for (int k = 0; k < cap.size(); k++) begin
            if (k / hold < nbits && cap[k] !== lit[k / hold]) mism++;
        end
        chk({name, "_bits"}, mism, 0);
    endtask

    task automatic cfg(input int div, input logic [1:0] db, input bit pen, input bit pev, input bit s2);
        divisor = 16'(div);
        data_bits = db;
        parity_en = pen;
        parity_even = pev;
        stop2 = s2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        #2;
        tx_en = 1'b1;
        valid = 1'b1;
        reset = 1'b1;
        #1;
        mon_on = 1'b1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        step(2);
        valid = 1'b0;
        reset = 1'b0;
        step(2);

        // divisor 3, 8N1, 0xA5; config scrambled right after acceptance
        cfg(3, 2'b11, 0, 0, 0);
        cap.delete();
        a0 = n_acc;
        send(8'hA5);
        valid = 1'b0;
        cfg(0, 2'b00, 1, 1, 1);
        wait_idle();
        check_cap("a5_8n1", 4, 10, 32'h34A);
        chk("a5_acc", n_acc - a0, 1);
        step(2);

        // divisor 0, 7E2, 0x7F: bit 7 dropped
        cfg(0, 2'b10, 1, 1, 1);
        cap.delete();
        send(8'h7F);
        valid = 1'b0;
        wait_idle();
        check_cap("7f_7e2", 1, 11, 32'h7FE);
        step(2);

        // divisor 1, 5O1, 0x03
        cfg(1, 2'b00, 1, 0, 0);
        cap.delete();
        send(8'h03);
        valid = 1'b0;
        wait_idle();
        check_cap("03_5o1", 2, 8, 32'hC6);
        step(2);

        // two pre-loaded words, 8N1, divisor 1
        cfg(1, 2'b11, 0, 0, 0);
        cap.delete();
        a0 = n_acc;
        send(8'h55);
        send(8'hC3);
        valid = 1'b0;
        wait_idle();
        check_cap("b2b", 2, 20, {12'h000, 10'h386, 10'h2AA});
        chk("b2b_gap", last_gap, 1);
        chk("b2b_acc", n_acc - a0, 2);
        step(2);

        // reset during data bit 3
        cfg(1, 2'b11, 0, 0, 0);
        send(8'h00);
        valid = 1'b0;
        step(8);
        chk("pre_rst_tx", tx, 0);
        chk("pre_rst_busy", busy, 1);
        a0 = n_acc;
        reset = 1'b1;
        valid = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 0);
        step(3);
        chk("rst_no_acc", n_acc - a0, 0);
        valid = 1'b0;
        reset = 1'b0;
        step(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_tx", tx, 1);

        // enable dropped during START
        cfg(2, 2'b11, 0, 0, 0);
        cap.delete();
        a0 = n_acc;
        send(8'h3C);
        step(1);
        tx_en = 1'b0;
        data = 8'h99;
        wait_idle();
        step(6);
        chk("txen_acc", n_acc - a0, 1);
        chk("txen_ready", ready, 0);
        check_cap("txen_frame", 3, 10, 32'h278);
        valid = 1'b0;
        tx_en = 1'b1;

        // no data: stays idle whatever the enable does
        step(3);
        tx_en = 1'b0;
        step(3);
        tx_en = 1'b1;
        step(2);
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);

        // word waiting while reset releases: taken on the first edge
        reset = 1'b1;
        step(1);
        cfg(0, 2'b11, 0, 0, 0);
        data = 8'h81;
        valid = 1'b1;
        a0 = n_acc;
        reset = 1'b0;
        step(1);
        valid = 1'b0;
        chk("first_edge_acc", n_acc - a0, 1);
        chk("first_edge_busy", busy, 1);
        wait_idle();
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_uart_tx.md
APB_UART_TX -- requirements
Module: apb_uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of data_i; DATA_WIDTH SHALL be 8.
REQ-002 Parameter: DIV_WIDTH, default 16, width of divisor_i.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tx_en_i  input  1  transmitter enable.
REQ-006 divisor_i  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-007 data_bits_i  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 parity_en_i  input  1  append a parity bit.
REQ-009 parity_even_i  input  1  1=even parity, 0=odd parity.
REQ-010 stop2_i  input  1  1=two stop bits, 0=one stop bit.
REQ-011 valid_i  input  1  upstream FIFO has a word.
REQ-012 data_i  input  DATA_WIDTH  upstream FIFO head word.
REQ-013 ready_o  output  1  word accepted this cycle (pop strobe to FIFO).
REQ-014 tx_o  output  1  serial line, idle high.
REQ-015 busy_o  output  1  frame in progress.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 ready_o SHALL be 1 only in IDLE with tx_en_i=1.
REQ-018 A transfer SHALL occur on valid_i && ready_o; data_i and all config inputs SHALL be latched on that edge, and the next state SHALL be START.
REQ-019 Config input changes after acceptance SHALL NOT affect the frame in progress.
REQ-020 Every bit SHALL last exactly divisor+1 clk cycles, timed by an internal down-counter reloaded at each bit boundary; divisor_i=0 gives 1 cycle per bit.
REQ-021 tx_o SHALL be 1 in IDLE, 0 in START, data bit LSB-first in DATA, parity in PARITY, and 1 in STOP; tx_o SHALL be registered (glitch-free).
REQ-022 DATA SHALL send 5/6/7/8 bits per latched data_bits; upper unused bits SHALL be ignored.
REQ-023 Parity SHALL be XOR of the transmitted data bits only; even: bit = XOR; odd: bit = ~XOR.
REQ-024 PARITY SHALL be skipped when the latched parity_en=0.
REQ-025 STOP SHALL last 1 or 2 bit periods per latched stop2.
REQ-026 After STOP, the FSM SHALL return to IDLE; if valid_i=1 and tx_en_i=1, the next word SHALL be accepted in that first IDLE cycle, so back-to-back frames have zero idle gap beyond one clk cycle.
REQ-027 Clearing tx_en_i mid-frame SHALL complete the current frame and then hold IDLE.
REQ-028 busy_o SHALL be 1 in every state other than IDLE.
REQ-029 With valid_i=0, the block SHALL stay in IDLE with tx_o=1, regardless of tx_en_i.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, tx_o=1, ready_o=0, busy_o=0, and clear the bit counter, baud counter and latched word.
REQ-031 Reset mid-frame SHALL abort the frame with no further line activity, and the word SHALL NOT be re-requested.
REQ-032 On the first edge after reset deassertion, ready_o MAY assert if tx_en_i=1.

Verification
REQ-033 divisor=3, 8N1, data 0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total; one ready_o pulse.
REQ-034 divisor=0, 7E2, data 0x7F -> start, 7 ones, parity 1, two stop bits, each held 1 cycle; bit 7 not sent.
REQ-035 5O1, data 0x03, divisor=1 -> data bits 1,1,0,0,0, parity 1, stop; 16 cycles.
REQ-036 Two words pre-loaded, 8N1, divisor=1 -> second start bit follows the last stop bit after exactly one IDLE cycle; ready_o pulses twice.
REQ-037 Reset asserted during DATA bit 3 -> tx_o=1 and busy_o=0 in the same cycle; no ready_o pulse until reset is released.
REQ-038 tx_en_i dropped during START -> frame completes unchanged; ready_o stays 0 afterwards while valid_i=1.
